phy_tx_lane_sched: RTL and testbench
====================================

Name: phy_tx_lane_sched

Overview:
Four-lane transmit scheduler that sits ahead of the PHY TX recirculation/mux/serializer chain on the clk_4f domain.
- Buffers bytes from four producers in per-lane FIFOs.
- Shares the single byte-wide serializer input among the lanes using round-robin.
- Gates traffic on the link-active indication from the control serial-parallel block.
- When valid_out is low, the serializer inserts COM/idle symbols.

Parameters:
DATA_W, 8, byte width per lane.
FIFO_DEPTH, 4, entries per lane FIFO; must be a power of 2.
PTR_W, 2, log2(FIFO_DEPTH); each lane count is PTR_W+1 bits wide.

Ports:
clk_4f  input  1  sole clock; all state updates on rising edge.
default_values  input  1  synchronous, active-low reset.
active  input  1  link-active from PHY control path; 1 = transmission allowed.
flush  input  1  discard all buffered bytes.
in_data0..in_data3  input  DATA_W each  lane producer byte.
in_valid0..in_valid3  input  1 each  lane producer byte valid.
in_ready0..in_ready3  output  1 each  lane FIFO can accept (combinational).
data_out  output  DATA_W  scheduled byte to serializer (registered).
valid_out  output  1  data_out valid (registered).
lane_id  output  2  source lane of data_out (registered).
fifo_empty  output  4  per-lane empty flags, bit i = lane i.

Behaviour:
- Reset: default_values=0 sampled at an edge causes the following.
  - All FIFO pointers and counts go to 0; fifo_empty=4'b1111.
  - state=WAIT; last_grant=3, so lane 0 has first priority.
  - data_out=0, valid_out=0, lane_id=0.
  - While default_values=0, in_ready0..3 are held 0.
  - Reset asserted mid-operation discards all queued bytes.
- Handshake: a write occurs at an edge when in_valid_i=1 and in_ready_i=1.
  - in_ready_i = default_values & !full_i & (state!=FLUSH).
  - full_i is based on the count before any same-cycle pop. A full FIFO therefore refuses the write even when it is popped in the same cycle.
  - A producer must hold in_data_i/in_valid_i until accepted.
- State machine, evaluated each edge with flush taking priority:
  - Any state: flush=1 -> FLUSH.
  - WAIT: active=1 -> RUN; else stay in WAIT.
  - RUN: active=0 -> WAIT; else stay in RUN.
  - FLUSH: flush=0 -> WAIT.
- FLUSH:
  - All pointers and counts cleared on every edge spent in FLUSH.
  - Writes blocked; valid_out=0.
  - last_grant is retained.
- Grant: computed combinationally when state==RUN && active==1.
  - Grant goes to the first non-empty lane searching last_grant+1, +2, +3, +4 mod 4.
  - At the edge, the granted FIFO pops; data_out/lane_id load the head byte/lane; valid_out=1; last_grant=granted lane.
  - No grant (all empty, WAIT, FLUSH, or active=0): valid_out=0; data_out and lane_id hold their values; last_grant holds.
- Latency:
  - A byte written at edge k into an empty FIFO can be granted at edge k+1 at the earliest.
  - It is then visible on data_out after edge k+1.
  - Throughput is one byte per clk_4f cycle.
- Active drop: active=0 in the cycle of an edge suppresses the pop at that same edge.
  - No byte is emitted after active is sampled low.
  - Queued bytes are preserved.
  - When active returns, the round-robin order resumes from last_grant+1.
- Simultaneous push/pop on one lane (non-full): count unchanged; both pointers advance.
- Pointer wrap: pointers are PTR_W bits and wrap naturally mod FIFO_DEPTH.
- fifo_empty_i = (count_i==0), taken from registered counts.

Decomposition:
- Shared include phy_tx_defs.vh holds the following, for use by later PHY control blocks:
  - State encodings ST_WAIT=2'd0, ST_RUN=2'd1, ST_FLUSH=2'd2.
  - LANES=4.
- One sub-module, phy_tx_lane_fifo, instantiated 4x.
  - Parameters: DATA_W, FIFO_DEPTH, PTR_W.
  - Inputs: clk_4f, default_values, clear, wr_en, wr_data, rd_en.
  - Outputs: rd_data (head, combinational), full, empty.
- The arbiter, the state machine and the output registers live in phy_tx_lane_sched.

Test Plan:
1. Reset: default_values=0 for 2 cycles with all in_valid=1 -> in_ready=4'b0000, valid_out=0, data_out=8'h00, fifo_empty=4'b1111.
2. Single lane: active=1, lane2 writes 8'hA5 then 8'hA6 on consecutive edges -> data_out A5 then A6 on consecutive cycles, lane_id=2, then valid_out=0.
3. Round-robin: with active=0, lane i is loaded with 8'h10+i then 8'h20+i; raise active -> data_out 10,11,12,13,20,21,22,23 with lane_id 0,1,2,3,0,1,2,3 back-to-back.
4. Full: with active=0, lane1 offers 5 bytes 8'h31..8'h35.
   - in_ready1 falls after the 4th acceptance; the 5th is held.
   - Raise active -> 31,32,33,34 drain; 35 is accepted once in_ready1 returns, then emitted.
5. Active drop: mid-stream of test 3, drop active after 8'h11 is emitted -> valid_out=0 the next cycle. Restore active -> output resumes with 8'h12 from lane 2; no byte is lost or duplicated.
6. Flush/reset mid-operation: 3 bytes queued on each lane; flush=1 for 1 cycle (repeat with default_values=0) -> fifo_empty=4'b1111, valid_out=0. After active=1, no stale bytes appear.

Source files
------------

// File: rtl/phy_tx_lane_sched_pkg.sv
// Shared definitions for the PHY TX lane scheduler and later PHY control blocks.
package phy_tx_lane_sched_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;

  // Scheduler state encodings, fixed so other PHY control blocks can decode them.
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Round-robin pick: first requesting lane searching last+1 .. last+4 (mod LANES).
  // Returns {found, lane}.
  function automatic logic [LANE_W:0] rr_pick(input logic [LANE_W-1:0] last,
                                              input logic [LANES-1:0]  req);
    logic [LANE_W:0]   res;
    logic [LANE_W-1:0] idx;
    res = '0;
    // Walk from the farthest candidate back to the nearest so the nearest wins.
    for (int k = int'(LANES); k >= 1; k--) begin
      idx = last + LANE_W'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/phy_tx_lane_fifo.sv
// Per-lane byte FIFO: registered pointers/count, combinational head read.
module phy_tx_lane_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic              clk_4f,
  input  logic              default_values,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  // Full/empty come from the registered count, before any same-cycle pop.
  assign full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = wr_en & ~full & default_values & ~clear;
  assign w_pop   = rd_en & ~empty & default_values & ~clear;
  assign rd_data = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; reset and clear both empty the FIFO.
  always_ff @(posedge clk_4f) begin
    if (!default_values || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Byte storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk_4f) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/phy_tx_lane_sched.sv
// Four-lane TX scheduler: per-lane FIFOs, round-robin onto one byte-wide
// serializer input, gated by link-active; flush discards everything queued.
module phy_tx_lane_sched
  import phy_tx_lane_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic              clk_4f,
  input  logic              default_values,
  input  logic              active,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  input  logic              in_valid0,
  input  logic              in_valid1,
  input  logic              in_valid2,
  input  logic              in_valid3,
  output logic              in_ready0,
  output logic              in_ready1,
  output logic              in_ready2,
  output logic              in_ready3,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        lane_id,
  output logic [3:0]        fifo_empty
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LANE_W-1:0] r_last_grant;

  logic [DATA_W-1:0] w_wr_data [LANES];
  logic [DATA_W-1:0] w_head    [LANES];
  logic [LANES-1:0]  w_valid;
  logic [LANES-1:0]  w_ready;
  logic [LANES-1:0]  w_full;
  logic [LANES-1:0]  w_empty;
  logic [LANES-1:0]  w_wr_en;
  logic [LANES-1:0]  w_rd_en;
  logic              w_clear;
  logic              w_arb_en;
  logic              w_pick_vld;
  logic [LANE_W-1:0] w_pick;
  logic              w_grant;

  assign w_wr_data[0] = in_data0;
  assign w_wr_data[1] = in_data1;
  assign w_wr_data[2] = in_data2;
  assign w_wr_data[3] = in_data3;
  assign w_valid      = {in_valid3, in_valid2, in_valid1, in_valid0};

  // FIFOs are wiped on every edge spent in FLUSH; writes are refused meanwhile.
  assign w_clear = (r_state == ST_FLUSH);
  assign w_ready = {LANES{default_values & ~w_clear}} & ~w_full;
  assign w_wr_en = w_valid & w_ready;

  assign in_ready0  = w_ready[0];
  assign in_ready1  = w_ready[1];
  assign in_ready2  = w_ready[2];
  assign in_ready3  = w_ready[3];
  assign fifo_empty = w_empty;

  // Arbitration only while running with the link up; active low blocks the pop.
  assign w_arb_en               = (r_state == ST_RUN) & active;
  assign {w_pick_vld, w_pick}   = rr_pick(r_last_grant, ~w_empty);
  assign w_grant                = w_arb_en & w_pick_vld;

  // One-hot pop of the granted lane.
  always_comb begin
    w_rd_en = '0;
    if (w_grant) w_rd_en[w_pick] = 1'b1;
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    phy_tx_lane_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .PTR_W     (PTR_W)
    ) u_fifo (
      .clk_4f        (clk_4f),
      .default_values(default_values),
      .clear         (w_clear),
      .wr_en         (w_wr_en[g]),
      .wr_data       (w_wr_data[g]),
      .rd_en         (w_rd_en[g]),
      .rd_data       (w_head[g]),
      .full          (w_full[g]),
      .empty         (w_empty[g])
    );
  end

  // State register.
  always_ff @(posedge clk_4f) begin
    if (!default_values) r_state <= ST_WAIT;
    else                 r_state <= w_state_nxt;
  end

  // Next state: flush overrides everything, otherwise follow link-active.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_FLUSH;
    end else begin
      case (r_state)
        ST_WAIT:  if (active)  w_state_nxt = ST_RUN;
        ST_RUN:   if (!active) w_state_nxt = ST_WAIT;
        ST_FLUSH: w_state_nxt = ST_WAIT;
        default:  w_state_nxt = ST_WAIT;
      endcase
    end
  end

  // Output registers and round-robin pointer; last_grant=3 puts lane 0 first.
  always_ff @(posedge clk_4f) begin
    if (!default_values) begin
      data_out     <= '0;
      valid_out    <= 1'b0;
      lane_id      <= '0;
      r_last_grant <= LANE_W'(LANES - 1);
    end else if (w_grant) begin
      data_out     <= w_head[w_pick];
      valid_out    <= 1'b1;
      lane_id      <= w_pick;
      r_last_grant <= w_pick;
    end else begin
      valid_out    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Randomized + directed bench for phy_tx_lane_sched with a queue-based
// reference model and an output scoreboard.
module tb_phy_tx_lane_sched;

  logic       clk_4f = 1'b0;
  logic       default_values = 1'b0;
  logic       active = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_data [4];
  logic [3:0] in_valid = 4'b0000;
  wire        in_ready0, in_ready1, in_ready2, in_ready3;
  wire [7:0]  data_out;
  wire        valid_out;
  wire [1:0]  lane_id;
  wire [3:0]  fifo_empty;
  wire [3:0]  rdy_vec = {in_ready3, in_ready2, in_ready1, in_ready0};

  always #5 clk_4f = ~clk_4f;

  phy_tx_lane_sched dut (
    .clk_4f(clk_4f), .default_values(default_values), .active(active), .flush(flush),
    .in_data0(in_data[0]), .in_data1(in_data[1]), .in_data2(in_data[2]), .in_data3(in_data[3]),
    .in_valid0(in_valid[0]), .in_valid1(in_valid[1]), .in_valid2(in_valid[2]), .in_valid3(in_valid[3]),
    .in_ready0(in_ready0), .in_ready1(in_ready1), .in_ready2(in_ready2), .in_ready3(in_ready3),
    .data_out(data_out), .valid_out(valid_out), .lane_id(lane_id), .fifo_empty(fifo_empty)
  );

  // Reference model: lane queues, link mode, last served lane, output registers.
  typedef enum {M_WAIT, M_RUN, M_FLUSH} mode_t;
  typedef struct packed {logic [1:0] lane; logic [7:0] data;} exp_t;

  logic [7:0] mq   [4][$];
  logic [7:0] pend [4][$];
  exp_t       sb[$];
  mode_t      mode = M_WAIT;
  int         last = 3;
  logic [7:0] m_dout = 8'h00;
  int         m_lane = 0;
  bit         m_vout = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         armed = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int i, input bit rst);
    return rst && (mode != M_FLUSH) && (mq[i].size() < 4);
  endfunction

  // One clock edge of the specified behaviour.
  task automatic model_step(input bit rst, input bit act, input bit fl);
    int   g;
    int   l;
    bit   rdy[4];
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      mode = M_WAIT; last = 3; m_dout = 8'h00; m_lane = 0; m_vout = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) rdy[i] = m_ready(i, 1'b1);
    g = -1;
    if (mode == M_RUN && act) begin
      for (int k = 1; k <= 4; k++) begin
        l = (last + k) % 4;
        if (g < 0 && mq[l].size() != 0) g = l;
      end
    end
    if (g >= 0) begin
      e.lane = 2'(g);
      e.data = mq[g].pop_front();
      sb.push_back(e);
      m_dout = e.data; m_lane = g; m_vout = 1'b1; last = g;
    end else begin
      m_vout = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (in_valid[i] && rdy[i]) begin
        mq[i].push_back(in_data[i]);
        void'(pend[i].pop_front());
      end
    end
    if (mode == M_FLUSH) for (int i = 0; i < 4; i++) mq[i].delete();
    if (fl)                  mode = M_FLUSH;
    else if (mode == M_FLUSH) mode = M_WAIT;
    else                     mode = act ? M_RUN : M_WAIT;
  endtask

  // Drive one cycle on the falling edge, check state, then advance the model.
  task automatic cyc(input bit rst, input bit act, input bit fl);
    logic [3:0] exp_rdy;
    logic [3:0] exp_empty;
    @(negedge clk_4f);
    default_values = rst; active = act; flush = fl;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = (pend[i].size() != 0);
      in_data[i]  = in_valid[i] ? pend[i][0] : 8'($urandom);
    end
    #1;
    if (armed) begin
      for (int i = 0; i < 4; i++) begin
        exp_rdy[i]   = m_ready(i, rst);
        exp_empty[i] = (mq[i].size() == 0);
      end
      check("in_ready",   32'(rdy_vec),    32'(exp_rdy));
      check("fifo_empty", 32'(fifo_empty), 32'(exp_empty));
      check("valid_out",  32'(valid_out),  32'(m_vout));
      check("data_out",   32'(data_out),   32'(m_dout));
      check("lane_id",    32'(lane_id),    32'(m_lane));
    end
    @(posedge clk_4f);
    model_step(rst, act, fl);
    armed = 1'b1;
  endtask

  // Scoreboard monitor: every byte the DUT presents must be the next expected one.
  always @(negedge clk_4f) begin
    exp_t e;
    if (armed && valid_out === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: lane %0d data %0h emitted, none expected", lane_id, data_out);
      end else begin
        e = sb.pop_front();
        if ({lane_id, data_out} !== {e.lane, e.data}) begin
          n_fail++;
          $display("FAIL sb_byte: got lane %0d data %0h expected lane %0d data %0h",
                   lane_id, data_out, e.lane, e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) in_data[i] = 8'h00;

    // Reset with every producer offering a byte.
    for (int i = 0; i < 4; i++) pend[i].push_back(8'hE0 + 8'(i));
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pend[i].delete();
    cyc(1'b0, 1'b0, 1'b0);

    // Single lane, back-to-back bytes.
    pend[2].push_back(8'hA5); pend[2].push_back(8'hA6);
    repeat (6) cyc(1'b1, 1'b1, 1'b0);

    // Full FIFO on lane 1 while inactive, then drain.
    for (int b = 0; b < 5; b++) pend[1].push_back(8'h31 + 8'(b));
    repeat (7)  cyc(1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b1, 1'b1, 1'b0);

    // Round-robin from reset priority, with an active drop mid-stream.
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pend[i].push_back(8'h10 + 8'(i));
      pend[i].push_back(8'h20 + 8'(i));
    end
    repeat (3)  cyc(1'b1, 1'b0, 1'b0);
    repeat (3)  cyc(1'b1, 1'b1, 1'b0);
    repeat (3)  cyc(1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b1, 1'b1, 1'b0);

    // Flush, then reset, with bytes queued on every lane.
    for (int i = 0; i < 4; i++) repeat (3) pend[i].push_back(8'($urandom));
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) repeat (3) pend[i].push_back(8'($urandom));
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0);

    // Random traffic with occasional link drops, flushes and resets.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 99) < 40 && pend[i].size() < 3) pend[i].push_back(8'($urandom));
      cyc(!($urandom_range(0, 99) < 2), $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 3);
    end

    // Drain everything and confirm nothing is left outstanding.
    repeat (40) cyc(1'b1, 1'b1, 1'b0);
    @(negedge clk_4f);
    #1;
    check("sb_leftover", 32'(sb.size()), 32'd0);
    check("model_empty", 32'(mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()), 32'd0);
    check("fifo_empty_end", 32'(fifo_empty), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
